// File: rtl/seq_shift_add_mult_if.sv
// Operand/result handshake bundle for the shift-and-add multiplier.
// The master side issues operands and consumes the product; the slave side is the multiplier.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product,
    output busy
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Multi-cycle unsigned shift-and-add multiplier.
// One conditional add of the multiplicand into the upper half of the partial
// product per cycle, followed by a right shift that carries the adder's
// carry-out into the MSB. Always takes WIDTH iterations, no early exit.
module seq_shift_add_mult #(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  seq_shift_add_mult_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     acc_hi;
  logic [WIDTH-1:0]     acc_lo;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   product_r;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   shifted;
  logic                 last_iter;

  // Conditional add of the multiplicand; the extra MSB keeps the carry-out.
  function automatic logic [WIDTH:0] add_step(
    input logic [WIDTH-1:0] hi,
    input logic [WIDTH-1:0] md,
    input logic             sel
  );
    logic [WIDTH:0] addend;
    addend   = sel ? {1'b0, md} : '0;
    add_step = {1'b0, hi} + addend;
  endfunction

  // Partial-product step: add, then shift {sum, acc_lo} right by one.
  always_comb begin
    sum       = add_step(acc_hi, mcand, acc_lo[0]);
    shifted   = {sum, acc_lo[WIDTH-1:1]};
    last_iter = (count == CNT_W'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        bus.busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers; all cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      count     <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand  <= bus.a;
            acc_hi <= '0;
            acc_lo <= bus.b;
            count  <= '0;
          end
        end
        BUSY: begin
          {acc_hi, acc_lo} <= shifted;
          count            <= count + 1'b1;
          if (last_iter) product_r <= shifted;
        end
        default: ;
      endcase
    end
  end

  // product holds its last completed value until overwritten or reset.
  assign bus.product = product_r;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed and randomized bench for seq_shift_add_mult.
// Expected products come from plain a*b arithmetic; expected timing comes
// from the documented latency (result visible 16 cycles after the accept edge).
module tb_seq_shift_add_mult;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH;

  logic clock;
  logic reset;
  int   total;
  int   passed;
  int   failed;

  seq_shift_add_mult_if #(.WIDTH(WIDTH)) bus ();

  seq_shift_add_mult #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // One full operation: accept, wait for completion, optional stall, unload.
  // With noise set, in_valid stays high with fresh random operands while busy/done.
  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        input int stall, input bit noise, input string tag);
    logic [2*WIDTH-1:0] exp;
    int cycles;
    exp = 32'(op_a) * 32'(op_b);
    check({tag, " in_ready_idle"}, bus.in_ready, 1);
    bus.a        = op_a;
    bus.b        = op_b;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = noise;
    if (noise) begin
      bus.a = WIDTH'($urandom);
      bus.b = WIDTH'($urandom);
    end else begin
      bus.a = '0;
      bus.b = '0;
    end
    check({tag, " busy_after_accept"}, {bus.busy, bus.in_ready, bus.out_valid}, 3'b100);
    cycles = 0;
    while (!bus.out_valid && cycles < 3 * LAT) begin
      tick();
      cycles++;
      if (noise) begin
        bus.a = WIDTH'($urandom);
        bus.b = WIDTH'($urandom);
      end
    end
    check({tag, " latency"}, cycles, LAT);
    check({tag, " product"}, bus.product, exp);
    check({tag, " done_flags"}, {bus.busy, bus.in_ready}, 2'b00);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        tick();
        if (noise) begin
          bus.a = WIDTH'($urandom);
          bus.b = WIDTH'($urandom);
        end
      end
      check({tag, " stall_valid"}, bus.out_valid, 1);
      check({tag, " stall_product"}, bus.product, exp);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " unload_flags"}, {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    check({tag, " product_kept"}, bus.product, exp);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    total  = 0;
    passed = 0;
    failed = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_product", bus.product, 0);

    // Idle with no request stays idle.
    tick();
    tick();
    check("idle_hold", {bus.in_ready, bus.busy, bus.out_valid}, 3'b100);

    run_op(16'h0003, 16'h0005, 0, 1'b0, "basic");
    run_op(16'hFFFF, 16'hFFFF, 0, 1'b0, "max_sq");
    run_op(16'h8000, 16'h0002, 0, 1'b0, "carry");
    run_op(16'h0000, 16'h1234, 0, 1'b0, "zero_a");
    run_op(16'hABCD, 16'h0001, 0, 1'b0, "ident");
    run_op(16'h1234, 16'h0000, 0, 1'b0, "zero_b");
    run_op(16'h7A5C, 16'hC3E1, 5, 1'b1, "bp_noise");

    // Abort in the 7th busy cycle: no result, back to idle with product cleared.
    bus.a         = 16'hBEEF;
    bus.b         = 16'h1357;
    bus.in_valid  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("abort_still_busy", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    check("abort_product", bus.product, 0);
    tick();
    check("abort_no_result", bus.out_valid, 0);
    run_op(16'h0010, 16'h0010, 0, 1'b0, "after_abort");

    for (int n = 0; n < 10; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 4)), 1'($urandom), $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
